// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button conditioner: per-channel FSM encoding
// and the hold/repeat counter width.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StPressed = 2'd1,
        StRepeat  = 2'd2
    } btn_state_e;

    // Wide enough to hold the larger of the two tick limits.
    function automatic int unsigned cnt_width(input int unsigned hold_ticks,
                                              input int unsigned repeat_ticks);
        int unsigned m;
        m = (hold_ticks > repeat_ticks) ? hold_ticks : repeat_ticks;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: debounce shift register with hysteresis, then a
// press/hold/auto-repeat FSM. The release pulse is named rel (release is a keyword).
module button_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEPTH        = 10,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic button,
    output logic level,
    output logic press,
    output logic rel,
    output logic rep,
    output logic step
);

    localparam int unsigned CW = cnt_width(HOLD_TICKS, REPEAT_TICKS);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TICKS - 1);
    localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_TICKS - 1);

    logic [DEPTH-1:0] sreg_q;
    logic             level_q, level_d;
    logic             tick_q;
    btn_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rep_q, rep_d;
    logic             rise, fall;

    // tick_q lines tick up with level, which lags the shift register by one clk,
    // so the tick that completes a press is never counted as a hold tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sreg_q  <= '0;
            level_q <= 1'b0;
            tick_q  <= 1'b0;
            state_q <= StIdle;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            if (tick) begin
                sreg_q <= {sreg_q[DEPTH-2:0], button};
            end
            level_q <= level_d;
            tick_q  <= tick;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
        end
    end

    always_comb begin
        level_d = level_q;
        if (&sreg_q) begin
            level_d = 1'b1;
        end else if (~|sreg_q) begin
            level_d = 1'b0;
        end
    end

    assign rise = level_d & ~level_q;
    assign fall = ~level_d & level_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rep_d   = 1'b0;
        if (fall) begin
            // Release wins over any repeat due on the same tick.
            state_d = StIdle;
            cnt_d   = '0;
            rel_d   = 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (rise) begin
                        state_d = StPressed;
                        cnt_d   = '0;
                        press_d = 1'b1;
                    end
                end
                StPressed: begin
                    if (tick_q) begin
                        if (cnt_q == HOLD_LAST) begin
                            state_d = StRepeat;
                            cnt_d   = '0;
                            rep_d   = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                StRepeat: begin
                    if (REPEAT_TICKS != 0 && tick_q) begin
                        if (cnt_q == REP_LAST) begin
                            cnt_d = '0;
                            rep_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign level = level_q;
    assign press = press_q;
    assign rel   = rel_q;
    assign rep   = rep_q;
    assign step  = press_q | rep_q;

endmodule

// File: rtl/button_conditioner.sv
// N-channel push-button front end: fans the shared sampling tick out to
// independent button_channel instances and packs their outputs.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned DEPTH        = 10,
    parameter int unsigned HOLD_TICKS   = 50,
    parameter int unsigned REPEAT_TICKS = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic [N-1:0] button,
    output logic [N-1:0] level,
    output logic [N-1:0] press,
    output logic [N-1:0] rel,
    output logic [N-1:0] rep,
    output logic [N-1:0] step
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        button_channel #(
            .DEPTH       (DEPTH),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .tick  (tick),
            .button(button[i]),
            .level (level[i]),
            .press (press[i]),
            .rel   (rel[i]),
            .rep   (rep[i]),
            .step  (step[i])
        );
    end

endmodule
